// File: rtl/interp_by4.sv
// Upsample-by-4 linear interpolator: each accepted sample yields four outputs
// ramping from the previous sample to the new one (or a zero-order hold).
module interp_by4 #(
    parameter int DATA_W = 8,
    parameter int INTERP = 1
) (
    input  logic              CLKin,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    input  logic              data_ready_in,
    output logic              busy
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state;
    logic [1:0]        phase;
    logic              primed;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] last;

    logic              in_acc;
    logic              out_acc;
    logic [DATA_W-1:0] new_base;
    logic [DATA_W-1:0] sel_base;
    logic [DATA_W-1:0] sel_target;
    logic [1:0]        sel_phase;
    logic [2:0]        mult;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W+2:0] prod;
    logic signed [DATA_W+2:0] step;
    logic signed [DATA_W+2:0] sum;
    logic [2:0]        unused_sum_hi;
    logic [DATA_W-1:0] next_out;

    // Ready in the final phase lets a new sample load on the same edge the
    // last output of the current ramp is taken, so the stream has no bubble.
    assign data_ready = (state == IDLE) || (phase == 2'd3 && data_ready_in);
    assign in_acc     = data_valid && data_ready;
    assign out_acc    = data_valid_out && data_ready_in;
    assign busy       = (state == EMIT);
    assign new_base   = primed ? last : data_in;

    // One shared interpolation datapath: either the first point of a new ramp
    // or the next point of the current one.
    always_comb begin
        sel_base   = in_acc ? new_base : base;
        sel_target = in_acc ? data_in : target;
        sel_phase  = in_acc ? 2'd0 : phase + 2'd1;
        mult       = {1'b0, sel_phase} + 3'd1;
        diff       = $signed({1'b0, sel_target}) - $signed({1'b0, sel_base});
        prod       = {{2{diff[DATA_W]}}, diff} * {{DATA_W{1'b0}}, mult};
        step       = prod >>> 2;
        sum        = $signed({3'b000, sel_base}) + step;
        next_out   = (INTERP != 0) ? sum[DATA_W-1:0] : sel_target;
    end

    // The result is bounded by base and target, so the top bits carry nothing.
    assign unused_sum_hi = sum[DATA_W+2:DATA_W];

    always_ff @(posedge CLKin) begin
        if (reset) begin
            state          <= IDLE;
            phase          <= 2'd0;
            primed         <= 1'b0;
            base           <= '0;
            target         <= '0;
            last           <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else if (in_acc) begin
            base           <= new_base;
            target         <= data_in;
            last           <= data_in;
            primed         <= 1'b1;
            phase          <= 2'd0;
            state          <= EMIT;
            data_out       <= next_out;
            data_valid_out <= 1'b1;
        end else if (out_acc) begin
            if (phase == 2'd3) begin
                data_valid_out <= 1'b0;
                state          <= IDLE;
            end else begin
                phase    <= phase + 2'd1;
                data_out <= next_out;
            end
        end
    end

endmodule

// File: tb/tb_interp_by4.sv
// Bench for interp_by4: linear and zero-order-hold builds side by side,
// checked cycle by cycle against an arithmetic queue model.
module tb_interp_by4;

    logic       CLKin = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       data_valid = 1'b0;
    logic       data_ready_in = 1'b1;
    logic       data_ready, data_valid_out, busy;
    logic [7:0] data_out;
    logic       data_ready0, data_valid_out0, busy0;
    logic [7:0] data_out0;

    int errors = 0;
    int checks = 0;
    int exp_lin[$];
    int exp_zoh[$];
    int got[$];
    int got0[$];
    bit primed = 1'b0;
    int last = 0;

    always #5 CLKin = ~CLKin;

    interp_by4 #(.DATA_W(8), .INTERP(1)) dut (
        .CLKin(CLKin), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .data_out(data_out), .data_valid_out(data_valid_out),
        .data_ready_in(data_ready_in), .busy(busy)
    );

    interp_by4 #(.DATA_W(8), .INTERP(0)) dut0 (
        .CLKin(CLKin), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready0), .data_out(data_out0), .data_valid_out(data_valid_out0),
        .data_ready_in(data_ready_in), .busy(busy0)
    );

    // Each accepted sample queues four outputs: base + floor((target-base)*k/4).
    task automatic model_accept(input int d);
        int b, num, q;
        b = primed ? last : d;
        for (int k = 1; k <= 4; k++) begin
            num = (d - b) * k;
            q = num / 4;
            if (num < 0 && (num % 4) != 0) q = q - 1;
            exp_lin.push_back(b + q);
            exp_zoh.push_back(d);
        end
        last = d;
        primed = 1'b1;
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later.
    task automatic step(input bit v, input int d, input bit rin, output bit took);
        bit exp_rdy;
        bit exp_vld;
        @(negedge CLKin);
        data_valid = v;
        data_in = d[7:0];
        data_ready_in = rin;
        #1;
        exp_vld = (exp_lin.size() > 0);
        exp_rdy = (exp_lin.size() == 0) || (exp_lin.size() == 1 && rin);
        checks += 6;
        if (data_ready !== exp_rdy) begin errors++; $display("FAIL ready: actual=%0b expected=%0b", data_ready, exp_rdy); end
        if (data_ready0 !== exp_rdy) begin errors++; $display("FAIL ready_zoh: actual=%0b expected=%0b", data_ready0, exp_rdy); end
        if (data_valid_out !== exp_vld) begin errors++; $display("FAIL valid_out: actual=%0b expected=%0b", data_valid_out, exp_vld); end
        if (data_valid_out0 !== exp_vld) begin errors++; $display("FAIL valid_out_zoh: actual=%0b expected=%0b", data_valid_out0, exp_vld); end
        if (busy !== exp_vld) begin errors++; $display("FAIL busy: actual=%0b expected=%0b", busy, exp_vld); end
        if (busy0 !== exp_vld) begin errors++; $display("FAIL busy_zoh: actual=%0b expected=%0b", busy0, exp_vld); end
        if (exp_vld) begin
            checks += 2;
            if (data_out !== exp_lin[0][7:0]) begin errors++; $display("FAIL data_out: actual=%0d expected=%0d", data_out, exp_lin[0]); end
            if (data_out0 !== exp_zoh[0][7:0]) begin errors++; $display("FAIL data_out_zoh: actual=%0d expected=%0d", data_out0, exp_zoh[0]); end
            if (rin) begin
                got.push_back(int'(data_out));
                got0.push_back(int'(data_out0));
                void'(exp_lin.pop_front());
                void'(exp_zoh.pop_front());
            end
        end
        took = v && exp_rdy;
        if (took) model_accept(d);
    endtask

    task automatic drain();
        bit t;
        for (int i = 0; i < 20 && exp_lin.size() > 0; i++) step(1'b0, 0, 1'b1, t);
        checks++;
        if (exp_lin.size() != 0) begin errors++; $display("FAIL drain_timeout: actual=%0d expected=0 pending", exp_lin.size()); end
    endtask

    task automatic send(input int d);
        bit t;
        got.delete();
        got0.delete();
        step(1'b1, d, 1'b1, t);
        checks++;
        if (!t) begin errors++; $display("FAIL send_accept: actual=0 expected=1 (sample %0d)", d); end
        drain();
    endtask

    task automatic do_reset();
        @(negedge CLKin);
        reset = 1'b1;
        data_valid = 1'b0;
        data_ready_in = 1'b1;
        exp_lin.delete();
        exp_zoh.delete();
        primed = 1'b0;
        last = 0;
        @(negedge CLKin);
        #1;
        checks += 4;
        if (data_out !== 8'd0) begin errors++; $display("FAIL rst_data_out: actual=%0d expected=0", data_out); end
        if (data_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_out: actual=%0b expected=0", data_valid_out); end
        if (data_out0 !== 8'd0) begin errors++; $display("FAIL rst_data_out_zoh: actual=%0d expected=0", data_out0); end
        if (data_valid_out0 !== 1'b0) begin errors++; $display("FAIL rst_valid_out_zoh: actual=%0b expected=0", data_valid_out0); end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bit t;
        do_reset();
        step(1'b0, 0, 1'b1, t);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: actual=%0b expected=0", busy); end
        if (data_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: actual=%0b expected=1", data_ready); end
    endtask

    task automatic test_ramp();
        int ins[6] = '{100, 200, 0, 10, 13, 10};
        int exps[6][4] = '{'{100, 100, 100, 100}, '{125, 150, 175, 200}, '{150, 100, 50, 0},
                           '{2, 5, 7, 10}, '{10, 11, 12, 13}, '{12, 11, 10, 10}};
        for (int g = 0; g < 6; g++) begin
            send(ins[g]);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got.size() != 4 || got[i] != exps[g][i])
                    begin errors++; $display("FAIL ramp_%0d_%0d: actual=%0d expected=%0d", ins[g], i, (i < got.size()) ? got[i] : -1, exps[g][i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit t;
        int e[4] = '{125, 150, 175, 200};
        send(100);
        got.delete();
        step(1'b1, 200, 1'b1, t);
        step(1'b0, 0, 1'b1, t);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 77, 1'b0, t);
            checks += 4;
            if (data_out !== 8'd150) begin errors++; $display("FAIL stall_data: actual=%0d expected=150", data_out); end
            if (data_valid_out !== 1'b1) begin errors++; $display("FAIL stall_valid: actual=%0b expected=1", data_valid_out); end
            if (data_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: actual=%0b expected=0", data_ready); end
            if (t) begin errors++; $display("FAIL stall_took: actual=1 expected=0"); end
        end
        drain();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got.size() != 4 || got[i] != e[i])
                begin errors++; $display("FAIL bp_seq_%0d: actual=%0d expected=%0d", i, (i < got.size()) ? got[i] : -1, e[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit t;
        int smp[3] = '{40, 80, 120};
        int e_lin[12] = '{40, 40, 40, 40, 50, 60, 70, 80, 90, 100, 110, 120};
        int e_zoh[12] = '{40, 40, 40, 40, 80, 80, 80, 80, 120, 120, 120, 120};
        int idx = 0;
        int gaps = 0;
        do_reset();
        got.delete();
        got0.delete();
        for (int c = 0; c < 40 && (idx < 3 || exp_lin.size() > 0); c++) begin
            step(idx < 3, (idx < 3) ? smp[idx] : 0, 1'b1, t);
            if (got.size() >= 1 && got.size() < 12 && !data_valid_out) gaps++;
            if (t) idx++;
        end
        checks += 2;
        if (idx != 3 || exp_lin.size() != 0) begin errors++; $display("FAIL b2b_timeout: actual=%0d expected=3 accepted", idx); end
        if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: actual=%0d expected=0", gaps); end
        for (int i = 0; i < 12; i++) begin
            checks += 2;
            if (got.size() != 12 || got[i] != e_lin[i])
                begin errors++; $display("FAIL b2b_lin_%0d: actual=%0d expected=%0d", i, (i < got.size()) ? got[i] : -1, e_lin[i]); end
            if (got0.size() != 12 || got0[i] != e_zoh[i])
                begin errors++; $display("FAIL b2b_zoh_%0d: actual=%0d expected=%0d", i, (i < got0.size()) ? got0[i] : -1, e_zoh[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit t;
        do_reset();
        send(100);
        got.delete();
        step(1'b1, 200, 1'b1, t);
        step(1'b0, 0, 1'b1, t);
        step(1'b0, 0, 1'b1, t);
        checks++;
        if (got.size() != 2 || got[0] != 125 || got[1] != 150)
            begin errors++; $display("FAIL mid_pre: actual=%0d outputs expected=2 (125,150)", got.size()); end
        do_reset();
        send(50);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got.size() != 4 || got[i] != 50)
                begin errors++; $display("FAIL mid_post_%0d: actual=%0d expected=50", i, (i < got.size()) ? got[i] : -1); end
        end
    endtask

    task automatic test_random();
        bit t;
        do_reset();
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)), $urandom_range(0, 9) < 8, t);
        drain();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
